// File: rtl/addsub_pkg.sv
// Shared types, widths and the small BCD splitter for the add/subtract calculator.
package addsub_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CALC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  localparam int OPW  = 4;
  localparam int RESW = 6;

  localparam int unsigned TIMEOUT_DEFAULT = 50_000_000;

  // Splits 0..30 into {tens, units} with a compare chain instead of a divider.
  function automatic logic [7:0] bcd_split(input logic [4:0] v);
    logic [3:0] t;
    logic [3:0] u;
    if (v >= 5'd30) begin
      t = 4'd3;
      u = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      t = 4'd2;
      u = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      t = 4'd1;
      u = 4'(v - 5'd10);
    end else begin
      t = 4'd0;
      u = v[3:0];
    end
    return {t, u};
  endfunction

endpackage

// File: rtl/addsub_sequencer_key_edge.sv
// ENTER key front end: two-flop synchronizer plus rising-edge detect.
module key_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);

  logic k1_q, k2_q, kp_q;

  // Synchronize the asynchronous key and keep the previous synchronized value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k1_q <= 1'b0;
      k2_q <= 1'b0;
      kp_q <= 1'b0;
    end else begin
      k1_q <= key_i;
      k2_q <= k1_q;
      kp_q <= k2_q;
    end
  end

  assign press_o = k2_q & ~kp_q;

endmodule

// File: rtl/addsub_sequencer.sv
// Operand entry FSM, 6-bit add/subtract and registered BCD display output.
module addsub_sequencer
  import addsub_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       sub,
  input  logic       key,
  output logic [3:0] dez,
  output logic [3:0] uni,
  output logic       neg,
  output logic [1:0] state,
  output logic       done
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [OPW-1:0]    a_q, a_d, b_q, b_d;
  logic              op_q, op_d;
  logic [RESW-2:0]   mag_q, mag_d;
  logic              negr_q, negr_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [3:0]        dez_q, dez_d, uni_q, uni_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic              press;
  logic [RESW-1:0]   res;
  logic [RESW-2:0]   disp_val;

  key_edge u_key_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .key_i   (key),
    .press_o (press)
  );

  // State, operand, result and display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      mag_q   <= '0;
      negr_q  <= 1'b0;
      tcnt_q  <= '0;
      dez_q   <= '0;
      uni_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      mag_q   <= mag_d;
      negr_q  <= negr_d;
      tcnt_q  <= tcnt_d;
      dez_q   <= dez_d;
      uni_q   <= uni_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  // Next-state, arithmetic and display selection.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    mag_d   = mag_q;
    negr_d  = negr_q;
    tcnt_d  = '0;
    done_d  = (state_q == S_CALC);

    res = op_q ? ({2'b00, a_q} - {2'b00, b_q}) : ({2'b00, a_q} + {2'b00, b_q});

    unique case (state_q)
      S_A: begin
        if (press) begin
          a_d     = sw;
          state_d = S_B;
        end
      end
      S_B: begin
        if (press) begin
          b_d     = sw;
          op_d    = sub;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        mag_d   = res[RESW-1] ? 5'(-res) : res[RESW-2:0];
        negr_d  = res[RESW-1];
        state_d = S_SHOW;
      end
      S_SHOW: begin
        tcnt_d = tcnt_q + 1'b1;
        if (press || tcnt_q == TLAST) state_d = S_A;
      end
      default: state_d = S_A;
    endcase

    disp_val       = (state_q == S_SHOW) ? mag_q : {1'b0, sw};
    {dez_d, uni_d} = bcd_split(disp_val);
    neg_d          = (state_q == S_SHOW) && negr_q;
  end

  assign dez   = dez_q;
  assign uni   = uni_q;
  assign neg   = neg_q;
  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Bench for addsub_sequencer: per-cycle behavioural model plus directed literal checks.
module tb_addsub_sequencer;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = '0;
  logic       sub = 1'b0;
  logic       key = 1'b0;
  logic [3:0] dez, uni;
  logic       neg, done;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  addsub_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .sub   (sub),
    .key   (key),
    .dez   (dez),
    .uni   (uni),
    .neg   (neg),
    .state (state),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase number, operands as integers, signed result.
  int m_st = 0, m_a = 0, m_b = 0, m_s = 0, m_res = 0, m_cnt = 0;
  int m_dez = 0, m_uni = 0, m_neg = 0, m_done = 0;
  int kh1 = 0, kh2 = 0, kh3 = 0;
  bit m_en = 0;

  always @(posedge clk) begin
    int v;
    bit pr;
    if (rst) begin
      m_en = 1;
      m_st = 0; m_a = 0; m_b = 0; m_s = 0; m_res = 0; m_cnt = 0;
      m_dez = 0; m_uni = 0; m_neg = 0; m_done = 0;
      kh1 = 0; kh2 = 0; kh3 = 0;
    end else begin
      pr = (kh2 != 0) && (kh3 == 0);
      if (m_st == 3) begin
        v     = (m_res < 0) ? -m_res : m_res;
        m_neg = (m_res < 0) ? 1 : 0;
      end else begin
        v     = int'(sw);
        m_neg = 0;
      end
      m_dez  = v / 10;
      m_uni  = v % 10;
      m_done = (m_st == 2) ? 1 : 0;
      case (m_st)
        0: if (pr) begin m_a = int'(sw); m_st = 1; end
        1: if (pr) begin m_b = int'(sw); m_s = int'(sub); m_st = 2; end
        2: begin
          m_res = (m_s != 0) ? (m_a - m_b) : (m_a + m_b);
          m_cnt = 0;
          m_st  = 3;
        end
        default: begin
          if (pr || m_cnt == TO - 1) m_st = 0;
          else m_cnt++;
        end
      endcase
      kh3 = kh2; kh2 = kh1; kh1 = int'(key);
    end
    #1;
    if (m_en) begin
      chk("model_state", int'(state), m_st);
      chk("model_done",  int'(done),  m_done);
      chk("model_dez",   int'(dez),   m_dez);
      chk("model_uni",   int'(uni),   m_uni);
      chk("model_neg",   int'(neg),   m_neg);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_key();
    @(negedge clk) key = 1'b1;
    @(negedge clk) key = 1'b0;
  endtask

  task automatic wait_state(input int s, input int bound, input string name);
    int n = 0;
    while (int'(state) != s && n < bound) begin
      tick();
      n++;
    end
    chk(name, int'(state), s);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  task automatic run_op(input int a, input int b, input int s,
                        input int ed, input int eu, input int en);
    wait_state(0, 30, "idle_before_op");
    @(negedge clk) sw = 4'(a);
    pulse_key();
    wait_state(1, 10, "enter_B");
    @(negedge clk) begin sw = 4'(b); sub = s[0]; end
    pulse_key();
    wait_done(10);
    chk("show_on_done", int'(state), 3);
    tick();
    chk("done_one_cycle", int'(done), 0);
    chk("res_dez", int'(dez), ed);
    chk("res_uni", int'(uni), eu);
    chk("res_neg", int'(neg), en);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int prev;
    int n;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_dez",   int'(dez),   0);
    chk("reset_uni",   int'(uni),   0);
    chk("reset_neg",   int'(neg),   0);
    chk("reset_done",  int'(done),  0);

    run_op(9, 3, 0, 1, 2, 0);
    run_op(3, 9, 1, 0, 6, 1);
    run_op(0, 15, 1, 1, 5, 1);
    run_op(15, 15, 0, 3, 0, 0);
    run_op(7, 7, 1, 0, 0, 0);

    // Key held for 100 cycles in S_A: exactly one step to S_B.
    wait_state(0, 30, "idle_before_hold");
    @(negedge clk) begin sw = 4'd4; key = 1'b1; end
    cnt = 0;
    prev = int'(state);
    repeat (100) begin
      tick();
      if (int'(state) != prev) cnt++;
      prev = int'(state);
    end
    @(negedge clk) key = 1'b0;
    chk("hold_transitions", cnt, 1);
    chk("hold_state_B", int'(state), 1);
    repeat (2) @(negedge clk);
    @(negedge clk) begin sw = 4'd4; sub = 1'b0; end
    pulse_key();
    wait_done(10);
    tick();
    chk("hold_sum_uni", int'(uni), 8);

    // Second key pulse right behind the B press: SHOW is still reached.
    wait_state(0, 30, "idle_before_calc_press");
    @(negedge clk) sw = 4'd6;
    pulse_key();
    wait_state(1, 10, "calc_press_B");
    @(negedge clk) begin sw = 4'd1; sub = 1'b1; key = 1'b1; end
    @(negedge clk) key = 1'b0;
    @(negedge clk) key = 1'b1;
    @(negedge clk) key = 1'b0;
    wait_state(3, 10, "calc_press_show");

    // Timeout: S_A exactly TO edges after SHOW entry.
    wait_state(0, 30, "idle_before_timeout");
    @(negedge clk) sw = 4'd2;
    pulse_key();
    wait_state(1, 10, "timeout_B");
    @(negedge clk) begin sw = 4'd2; sub = 1'b0; end
    pulse_key();
    wait_done(10);
    n = 0;
    while (int'(state) != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("timeout_edges", n, TO);

    // Press landing on the timeout edge gives a single return to S_A.
    @(negedge clk) sw = 4'd1;
    pulse_key();
    wait_state(1, 10, "tpress_B");
    @(negedge clk) begin sw = 4'd1; sub = 1'b0; end
    pulse_key();
    wait_done(10);
    repeat (6) @(negedge clk);
    key = 1'b1;
    @(negedge clk) key = 1'b0;
    wait_state(0, 10, "tpress_return");
    tick();
    tick();
    chk("tpress_stays_A", int'(state), 0);

    // Reset while waiting for operand B.
    repeat (3) @(negedge clk);
    sw = 4'd5;
    pulse_key();
    wait_state(1, 10, "rst_mid_B");
    @(negedge clk) begin rst = 1'b1; sw = 4'd7; end
    @(negedge clk) rst = 1'b0;
    chk("rst_mid_state", int'(state), 0);
    chk("rst_mid_dez", int'(dez), 0);
    chk("rst_mid_uni", int'(uni), 0);
    tick();
    chk("rst_live_uni", int'(uni), 7);
    repeat (3) @(negedge clk);
    run_op(2, 4, 0, 0, 6, 0);

    repeat (12) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
